// File: rtl/up_dn_counter_pkg.sv
// Shared types for the loadable saturating up/down counter.
// Operation select and default width live here.
package up_dn_counter_pkg;

  localparam int CNT_W_DEFAULT = 5;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_DEC,
    OP_INC
  } op_e;

  // Load beats down, down beats up.
  function automatic op_e sel_op(
    input logic load,
    input logic down,
    input logic up
  );
    op_e op;
    op = OP_HOLD;
    unique case (1'b1)
      load:                  op = OP_LOAD;
      !load && down:         op = OP_DEC;
      !load && !down && up:  op = OP_INC;
      default:               op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/up_dn_counter_next.sv
// Next-count logic: priority decode plus saturate or wrap at the ends.
// UP_DN_COUNTER_WRAP_EN selects modulo counting instead of saturation.
module up_dn_counter_next
  import up_dn_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_load,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  op_e              w_op;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  assign w_op     = sel_op(i_load, i_down, i_up);
  assign w_at_max = (i_cnt == ALL1);
  assign w_at_min = (i_cnt == '0);

`ifdef UP_DN_COUNTER_WRAP_EN
  assign w_inc = i_cnt + ONE;
  assign w_dec = i_cnt - ONE;
`else
  assign w_inc = w_at_max ? i_cnt : i_cnt + ONE;
  assign w_dec = w_at_min ? i_cnt : i_cnt - ONE;
`endif

  always_comb begin
    o_next = i_cnt;
    unique case (w_op)
      OP_LOAD: o_next = i_in;
      OP_DEC:  o_next = w_dec;
      OP_INC:  o_next = w_inc;
      OP_HOLD: o_next = i_cnt;
      default: o_next = i_cnt;
    endcase
  end

endmodule

// File: rtl/up_dn_counter_sat.sv
// Counter register and High/Low decode; next value comes from
// up_dn_counter_next. Build option: UP_DN_COUNTER_WRAP_EN.
module up_dn_counter_sat
  import up_dn_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] In,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_next;

  up_dn_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_cnt  (r_cnt),
    .i_in   (In),
    .i_load (Load),
    .i_up   (Up),
    .i_down (Down),
    .o_next (w_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_cnt <= '0;
    else     r_cnt <= w_next;
  end

  assign Counter = r_cnt;
  assign High    = (r_cnt == {WIDTH{1'b1}});
  assign Low     = (r_cnt == '0);

endmodule

// File: tb/tb_up_dn_counter_sat.sv
// Bench for up_dn_counter_sat: directed plan plus random stimulus
// against an integer reference model.
module tb_up_dn_counter_sat;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;
`ifdef UP_DN_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] In = '0;
  logic         Load = 1'b0;
  logic         Up = 1'b0;
  logic         Down = 1'b0;
  logic [W-1:0] Counter;
  logic         High;
  logic         Low;

  int n_tests = 0;
  int n_fail  = 0;
  int m = 0;

  up_dn_counter_sat #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .In      (In),
    .Load    (Load),
    .Up      (Up),
    .Down    (Down),
    .Counter (Counter),
    .High    (High),
    .Low     (Low)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input bit up,
                      input bit dn, input int din, input string tag);
    RST  = rst;
    Load = ld;
    Up   = up;
    Down = dn;
    In   = W'(din);
    @(posedge CLK);
    if (rst)     m = 0;
    else if (ld) m = din;
    else if (dn) m = (m == 0) ? (WRAP ? MAX : 0) : m - 1;
    else if (up) m = (m == MAX) ? (WRAP ? 0 : MAX) : m + 1;
    #1;
    chk({tag, "_cnt"},  int'(Counter), m);
    chk({tag, "_high"}, int'(High), int'(m == MAX));
    chk({tag, "_low"},  int'(Low), int'(m == 0));
  endtask

  initial begin
    step(1, 1, 0, 0, 9, "reset");
    chk("reset_const", int'(Counter), 0);

    step(0, 1, 0, 0, 1, "load");
    step(0, 1, 1, 0, 1, "load_up");
    step(0, 1, 1, 1, 1, "load_updn");
    chk("load_const", int'(Counter), 1);

    repeat (3) step(0, 0, 1, 0, 0, "up");
    chk("up_const", int'(Counter), 4);
    step(0, 0, 0, 1, 0, "down");
    chk("down_const", int'(Counter), 3);
    repeat (4) step(0, 0, 1, 1, 0, "updn");
`ifndef UP_DN_COUNTER_WRAP_EN
    chk("updn_const", int'(Counter), 0);
`endif

    step(0, 1, 0, 0, 29, "ld29");
    repeat (4) step(0, 0, 1, 0, 0, "upsat");
`ifndef UP_DN_COUNTER_WRAP_EN
    chk("upsat_const", int'(Counter), 31);
`endif

    step(0, 1, 0, 0, 0, "ld0");
    repeat (3) step(0, 0, 0, 1, 0, "dnsat");

    step(0, 1, 0, 0, MAX, "ldmax");
    step(0, 0, 1, 0, 0, "edge_up");
    step(0, 1, 0, 0, 0, "ldmin");
    step(0, 0, 0, 1, 0, "edge_dn");

    for (int i = 0; i < 400; i++) begin
      int r;
      int d;
      r = $urandom_range(0, 99);
      d = (r < 10) ? 0 : (r < 20) ? MAX : (r < 25) ? MAX - 1 :
          int'($urandom_range(0, MAX));
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
